// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage sitting directly in front of the program ROM.
//   Keeps the program counter, reads one ROM word per cycle while the
//   downstream decoder keeps up, and holds the fetched word in a single-entry
//   instruction register that is offered to the decoder over valid/ready.
//   Supports branch redirect (with flush), a halt opcode and PC wrap-around.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   synchronous active-high reset
//   start          in   leave IDLE and begin fetching at the current PC
//   rom_addr       out  ROM word address (always the PC register)
//   rom_enable     out  ROM read strobe, high on cycles that fetch
//   rom_opcode     in   ROM word [31:16], combinational from rom_addr
//   rom_operand    in   ROM word [15:0], combinational from rom_addr
//   branch_taken   in   redirect request from execute
//   branch_target  in   redirect address
//   instr_valid    out  instruction register holds an instruction
//   instr_ready    in   decoder takes the instruction this cycle
//   instr_opcode   out  captured opcode
//   instr_operand  out  captured operand
//   instr_pc       out  address the captured instruction came from
//   halted         out  halt opcode fetched and instruction register drained
//   addr_fault     out  sticky flag: a branch target beyond PC_MAX was seen
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] PC_MAX      = 16'd256,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = 16'd0,
  parameter logic [DATA_WIDTH-1:0] HALT_OPCODE = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] rom_addr,
  output logic                  rom_enable,
  input  logic [DATA_WIDTH-1:0] rom_opcode,
  input  logic [DATA_WIDTH-1:0] rom_operand,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_target,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_opcode,
  output logic [DATA_WIDTH-1:0] instr_operand,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic                  halted,
  output logic                  addr_fault
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] pc_p0;
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] opcode_p1;
  logic [DATA_WIDTH-1:0] operand_p1;
  logic [DATA_WIDTH-1:0] ipc_p1;
  logic                  fault_q;

  logic fetch;
  logic branch_act;
  logic target_bad;

  // Sequential PC advance; the last ROM word wraps back to address 0.
  function automatic logic [DATA_WIDTH-1:0] pc_incr(input logic [DATA_WIDTH-1:0] pc);
    return (pc == PC_MAX) ? '0 : pc + 1'b1;
  endfunction

  // Out-of-range redirect targets are clamped to address 0.
  function automatic logic [DATA_WIDTH-1:0] pc_redirect(input logic [DATA_WIDTH-1:0] tgt);
    return (tgt > PC_MAX) ? '0 : tgt;
  endfunction

  // A branch overrides fetch in the same cycle; HALTED ignores branches.
  assign branch_act = branch_taken && (state_q != HALTED);
  assign target_bad = branch_target > PC_MAX;
  assign fetch      = (state_q == RUN) && (!vld_p1 || instr_ready) && !branch_taken;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (fetch && (rom_opcode == HALT_OPCODE)) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0 -> p1: PC register feeds the ROM, ROM word lands in the IR.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_p0      <= RESET_PC;
      vld_p1     <= 1'b0;
      opcode_p1  <= '0;
      operand_p1 <= '0;
      ipc_p1     <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (branch_act) begin
        // Flush: any instruction accepted this edge still completes, the rest
        // of the old stream is dropped.
        pc_p0  <= pc_redirect(branch_target);
        vld_p1 <= 1'b0;
        if (target_bad) fault_q <= 1'b1;
      end else if (fetch) begin
        opcode_p1  <= rom_opcode;
        operand_p1 <= rom_operand;
        ipc_p1     <= pc_p0;
        vld_p1     <= 1'b1;
        pc_p0      <= pc_incr(pc_p0);
      end else if (vld_p1 && instr_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign rom_addr      = pc_p0;
  assign rom_enable    = fetch;
  assign instr_valid   = vld_p1;
  assign instr_opcode  = opcode_p1;
  assign instr_operand = operand_p1;
  assign instr_pc      = ipc_p1;
  assign halted        = (state_q == HALTED) && !vld_p1;
  assign addr_fault    = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, start, branch_taken, instr_ready;
  logic [15:0] branch_target;
  logic [15:0] rom_addr, rom_opcode, rom_operand;
  logic        rom_enable, instr_valid, halted, addr_fault;
  logic [15:0] instr_opcode, instr_operand, instr_pc;

  logic [31:0] rom [0:256];
  logic [31:0] rom_word;

  int checks = 0;
  int errors = 0;

  // Reference model: abstract machine (mode, next address, held instruction)
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
  int          m_mode;
  int          m_pc;
  bit          m_valid, m_fault;
  logic [15:0] m_op, m_opd, m_ipc;

  fetch_unit dut (
    .clk(clk), .rst(rst), .start(start),
    .rom_addr(rom_addr), .rom_enable(rom_enable),
    .rom_opcode(rom_opcode), .rom_operand(rom_operand),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_operand(instr_operand),
    .instr_pc(instr_pc), .halted(halted), .addr_fault(addr_fault)
  );

  always #5 clk = ~clk;

  always_comb begin
    rom_word = 32'h0;
    if (rom_addr <= 16'd256) rom_word = rom[rom_addr[8:0]];
  end
  assign rom_opcode  = rom_word[31:16];
  assign rom_operand = rom_word[15:0];

  function automatic logic [31:0] rom_at(input int a);
    return (a >= 0 && a <= 256) ? rom[a] : 32'h0;
  endfunction

  function automatic bit m_fetch();
    return (m_mode == M_RUN) && (!m_valid || instr_ready) && !branch_taken;
  endfunction

  task automatic model_edge();
    bit          f;
    logic [31:0] w;
    if (rst) begin
      m_mode = M_IDLE; m_pc = 0; m_valid = 0; m_fault = 0;
      m_op = 0; m_opd = 0; m_ipc = 0;
    end else begin
      f = m_fetch();
      w = rom_at(m_pc);
      if (m_mode == M_IDLE && start) m_mode = M_RUN;
      else if (f && w[31:16] == 16'hFFFF) m_mode = M_HALT;
      if (branch_taken && m_mode_before_halt_ok(f, w)) begin
        if (int'(branch_target) > 256) begin m_pc = 0; m_fault = 1; end
        else m_pc = int'(branch_target);
        m_valid = 0;
      end else if (f) begin
        m_op = w[31:16]; m_opd = w[15:0]; m_ipc = 16'(m_pc);
        m_valid = 1;
        m_pc = (m_pc + 1) % 257;
      end else if (m_valid && instr_ready) begin
        m_valid = 0;
      end
    end
  endtask

  // Branches are ignored only when the machine was already halted before the
  // edge; a fetch cannot coexist with a branch, so a halt entered this edge
  // implies no branch was pending.
  function automatic bit m_mode_before_halt_ok(input bit f, input logic [31:0] w);
    return !(m_mode == M_HALT && !(f && w[31:16] == 16'hFFFF));
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input bit s, input bit b, input logic [15:0] t, input bit r);
    start = s; branch_taken = b; branch_target = t; instr_ready = r;
  endtask

  task automatic do_reset();
    rst = 1'b1; set_in(0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (rom_enable !== 1'b0 || instr_valid !== 1'b0 || rom_addr !== 16'd0 ||
        halted !== 1'b0 || addr_fault !== 1'b0 || instr_opcode !== 16'd0 ||
        instr_operand !== 16'd0 || instr_pc !== 16'd0) begin
      errors++;
      $display("FAIL reset: en=%0b vld=%0b addr=%h halt=%0b flt=%0b op=%h opd=%h pc=%h required all zero",
               rom_enable, instr_valid, rom_addr, halted, addr_fault, instr_opcode, instr_operand, instr_pc);
    end
  endtask

  task automatic test_stream();
    logic [15:0] eop [3] = '{16'h3101, 16'h0000, 16'h0000};
    logic [15:0] eopd[3] = '{16'h0005, 16'h0007, 16'h0009};
    rom[0] = 32'h3101_0005; rom[1] = 32'h0000_0007; rom[2] = 32'h0000_0009;
    set_in(1, 0, 0, 1);
    tick();
    start = 1'b0;
    checks++;
    if (rom_enable !== 1'b1 || rom_addr !== 16'd0) begin
      errors++;
      $display("FAIL stream_first_fetch: en=%0b addr=%h required en=1 addr=0000", rom_enable, rom_addr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 16'(i) || instr_opcode !== eop[i] ||
          instr_operand !== eopd[i] || rom_enable !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d: vld=%0b pc=%h op=%h opd=%h en=%0b required 1 %h %h %h 1",
                 i, instr_valid, instr_pc, instr_opcode, instr_operand, rom_enable, 16'(i), eop[i], eopd[i]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    set_in(1, 0, 0, 1);
    tick();
    start = 1'b0;
    tick();
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 16'd0 || instr_opcode !== 16'h3101 ||
          rom_enable !== 1'b0 || rom_addr !== 16'd1) begin
        errors++;
        $display("FAIL stall_%0d: vld=%0b pc=%h op=%h en=%0b addr=%h required 1 0000 3101 0 0001",
                 i, instr_valid, instr_pc, instr_opcode, rom_enable, rom_addr);
      end
      tick();
    end
    instr_ready = 1'b1;
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'd1) begin
      errors++;
      $display("FAIL stall_release: vld=%0b pc=%h required 1 0001", instr_valid, instr_pc);
    end
  endtask

  task automatic test_branch();
    rom[16'h40] = 32'h1234_5678;
    set_in(0, 1, 16'h0040, 1);
    #1;
    checks++;
    if (rom_enable !== 1'b0) begin
      errors++;
      $display("FAIL branch_no_fetch: en=%0b required 0", rom_enable);
    end
    tick();
    branch_taken = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || rom_addr !== 16'h0040) begin
      errors++;
      $display("FAIL branch_flush: vld=%0b addr=%h required 0 0040", instr_valid, rom_addr);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0040 || instr_opcode !== 16'h1234 ||
        instr_operand !== 16'h5678) begin
      errors++;
      $display("FAIL branch_target: vld=%0b pc=%h op=%h opd=%h required 1 0040 1234 5678",
               instr_valid, instr_pc, instr_opcode, instr_operand);
    end
  endtask

  task automatic test_wrap();
    rom[256] = 32'hAAAA_BBBB;
    set_in(0, 1, 16'd256, 1);
    tick();
    branch_taken = 1'b0;
    tick();
    checks++;
    if (instr_pc !== 16'd256 || instr_opcode !== 16'hAAAA || rom_addr !== 16'd0) begin
      errors++;
      $display("FAIL wrap_last: pc=%h op=%h addr=%h required 0100 aaaa 0000", instr_pc, instr_opcode, rom_addr);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'd0) begin
      errors++;
      $display("FAIL wrap_zero: vld=%0b pc=%h required 1 0000", instr_valid, instr_pc);
    end
    set_in(0, 1, 16'h0200, 1);
    tick();
    branch_taken = 1'b0;
    checks++;
    if (addr_fault !== 1'b1 || rom_addr !== 16'd0) begin
      errors++;
      $display("FAIL bad_target: flt=%0b addr=%h required 1 0000", addr_fault, rom_addr);
    end
    repeat (3) tick();
    checks++;
    if (addr_fault !== 1'b1) begin
      errors++;
      $display("FAIL fault_sticky: flt=%0b required 1", addr_fault);
    end
  endtask

  task automatic test_halt();
    bit seen = 0;
    do_reset();
    rom[0] = 32'h3101_0005; rom[1] = 32'h0000_0007; rom[2] = 32'h0000_0009;
    rom[3] = 32'hFFFF_0000;
    set_in(1, 0, 0, 1);
    tick();
    start = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (instr_valid && instr_pc == 16'd3) seen = 1;
    end
    checks++;
    if (!seen || instr_opcode !== 16'hFFFF || rom_enable !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_deliver: seen=%0b op=%h en=%0b halt=%0b required 1 ffff 0 0",
               seen, instr_opcode, rom_enable, halted);
    end
    tick();
    checks++;
    if (halted !== 1'b1 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_drained: halt=%0b vld=%0b required 1 0", halted, instr_valid);
    end
    set_in(1, 1, 16'h0010, 1);
    tick();
    set_in(0, 0, 0, 1);
    #1;
    checks++;
    if (halted !== 1'b1 || rom_addr !== 16'd4 || rom_enable !== 1'b0) begin
      errors++;
      $display("FAIL halt_ignore: halt=%0b addr=%h en=%0b required 1 0004 0", halted, rom_addr, rom_enable);
    end
    do_reset();
    checks++;
    if (halted !== 1'b0 || rom_addr !== 16'd0) begin
      errors++;
      $display("FAIL halt_reset: halt=%0b addr=%h required 0 0000", halted, rom_addr);
    end
  endtask

  task automatic test_reset_stall();
    rom[3] = 32'h0003_0003;
    set_in(1, 0, 0, 0);
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || rom_addr !== 16'd0 || rom_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_stalled: vld=%0b addr=%h en=%0b required 0 0000 0", instr_valid, rom_addr, rom_enable);
    end
  endtask

  task automatic test_random();
    for (int a = 0; a <= 256; a++) begin
      rom[a] = $urandom;
      if ($urandom_range(63) == 0) rom[a][31:16] = 16'hFFFF;
      else if (rom[a][31:16] == 16'hFFFF) rom[a][31:16] = 16'h0;
    end
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(59) == 0);
      set_in($urandom_range(7) == 0, $urandom_range(9) == 0,
             16'($urandom_range(300)), $urandom_range(9) < 7);
      #1;
      checks++;
      if (rom_enable !== (!rst && m_fetch()) && !rst || rom_addr !== 16'(m_pc)) begin
        errors++;
        $display("FAIL rand_comb cyc%0d: en=%0b addr=%h required %0b %h", c, rom_enable, rom_addr, m_fetch(), 16'(m_pc));
      end
      tick();
      checks++;
      if (instr_valid !== m_valid || addr_fault !== m_fault ||
          halted !== (m_mode == M_HALT && !m_valid) ||
          (m_valid && (instr_pc !== m_ipc || instr_opcode !== m_op || instr_operand !== m_opd))) begin
        errors++;
        $display("FAIL rand_state cyc%0d: vld=%0b flt=%0b halt=%0b pc=%h op=%h opd=%h required %0b %0b %0b %h %h %h",
                 c, instr_valid, addr_fault, halted, instr_pc, instr_opcode, instr_operand,
                 m_valid, m_fault, (m_mode == M_HALT && !m_valid), m_ipc, m_op, m_opd);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0);
    for (int a = 0; a <= 256; a++) rom[a] = 32'h0;
    m_mode = M_IDLE; m_pc = 0; m_valid = 0; m_fault = 0; m_op = 0; m_opd = 0; m_ipc = 0;
    #2;
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_wrap();
    test_halt();
    test_reset_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not finish, required finish before 900000");
    $fatal(1, "timeout");
  end

endmodule
